// File: rtl/rank_aer_encoder_pkg.sv
// Shared definitions for the rank-order AER encoder: default geometry and FSM states.
package paSnnAccelerator;

  function automatic int index_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IMAGE_SIZE = 5;
  localparam int INDEX_BITS = index_bits(IMAGE_SIZE);
  localparam int ADDR_BITS  = 8;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    WAIT_ACK_HI,
    WAIT_ACK_LO
  } state_e;

endpackage

// File: rtl/rank_aer_encoder_ack_sync.sv
// Two-flop synchronizer for the AER acknowledge; only present when AER_ACK_SYNC_EN is defined.
`ifdef AER_ACK_SYNC_EN
module aer_ack_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ack_i,
  output logic ack_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= ack_i;
      sync_q <= meta_q;
    end
  end

  assign ack_o = sync_q;

endmodule
`endif

// File: rtl/rank_aer_encoder.sv
// Rank-order AER encoder: streams sorted pixel indexes over a 4-phase AER link.
// Define AER_ACK_SYNC_EN to put a 2-flop synchronizer on AEROUT_ACK.
module rank_aer_encoder
  import paSnnAccelerator::state_e, paSnnAccelerator::IDLE, paSnnAccelerator::SETUP,
         paSnnAccelerator::WAIT_ACK_HI, paSnnAccelerator::WAIT_ACK_LO;
#(
  parameter int IMAGE_SIZE = paSnnAccelerator::IMAGE_SIZE,
  parameter int NUM_EVENTS = IMAGE_SIZE,
  parameter int ADDR_BITS  = paSnnAccelerator::ADDR_BITS,
  localparam int INDEX_BITS = paSnnAccelerator::index_bits(IMAGE_SIZE)
) (
  input  logic                                 CLK,
  input  logic                                 RST,
  input  logic [IMAGE_SIZE-1:0][INDEX_BITS-1:0] sorted_indexes,
  input  logic                                 done,
  output logic [ADDR_BITS-1:0]                 AEROUT_ADDR,
  output logic                                 AEROUT_REQ,
  input  logic                                 AEROUT_ACK,
  output logic                                 busy,
  output logic                                 image_sent,
  output logic                                 overrun
);

  logic                                  ack_s;
  state_e                                state_q;
  logic [IMAGE_SIZE-1:0][INDEX_BITS-1:0] buf_q;
  logic [INDEX_BITS-1:0]                 rank_q;
  logic [INDEX_BITS-1:0]                 rank_d;
  logic [ADDR_BITS-1:0]                  addr_q;
  logic                                  req_q;
  logic                                  busy_q;
  logic                                  sent_q;
  logic                                  ovr_q;
  logic                                  last_rank;

`ifdef AER_ACK_SYNC_EN
  aer_ack_sync u_ack_sync (
    .clk_i  (CLK),
    .rst_ni (RST),
    .ack_i  (AEROUT_ACK),
    .ack_o  (ack_s)
  );
`else
  assign ack_s = AEROUT_ACK;
`endif

  assign rank_d    = rank_q + 1'b1;
  assign last_rank = (rank_q == INDEX_BITS'(NUM_EVENTS - 1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      buf_q   <= '0;
      rank_q  <= '0;
      addr_q  <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      sent_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sent_q <= 1'b0;
      if (done && (state_q != IDLE)) begin
        ovr_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (done) begin
            buf_q   <= sorted_indexes;
            rank_q  <= '0;
            addr_q  <= ADDR_BITS'(sorted_indexes[0]);
            busy_q  <= 1'b1;
            state_q <= SETUP;
          end
        end
        // REQ may only rise once the receiver has released ACK from the previous phase.
        SETUP: begin
          if (!ack_s) begin
            req_q   <= 1'b1;
            state_q <= WAIT_ACK_HI;
          end
        end
        WAIT_ACK_HI: begin
          if (ack_s) begin
            req_q   <= 1'b0;
            state_q <= WAIT_ACK_LO;
          end
        end
        WAIT_ACK_LO: begin
          if (!ack_s) begin
            if (last_rank) begin
              busy_q  <= 1'b0;
              sent_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              rank_q  <= rank_d;
              addr_q  <= ADDR_BITS'(buf_q[rank_d]);
              state_q <= SETUP;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign AEROUT_ADDR = addr_q;
  assign AEROUT_REQ  = req_q;
  assign busy        = busy_q;
  assign image_sent  = sent_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_rank_aer_encoder.sv
// Scoreboard bench for rank_aer_encoder: full-length and NUM_EVENTS=2 instances, emulated AER receivers.
module tb_rank_aer_encoder;

`ifdef AER_ACK_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic            CLK = 1'b0;
  logic            RST = 1'b0;
  logic [4:0][2:0] si = '0;
  logic            done = 1'b0;
  logic            done2 = 1'b0;
  logic [7:0]      addr1, addr2;
  logic            req1, req2, busy1, busy2, sent1, sent2, ovr1, ovr2;
  logic            ack1, ack2;
  logic            auto_ack = 1'b1;
  logic            man_ack = 1'b0;
  logic            resp_ack1 = 1'b0;
  logic            resp_ack2 = 1'b0;

  int              n_chk = 0;
  int              n_fail = 0;
  int              q1[$];
  int              q2[$];
  int              ev1 = 0, ev2 = 0, nsent1 = 0, nsent2 = 0;
  logic            prev_req1 = 1'b0, prev_req2 = 1'b0;
  logic [7:0]      held1 = '0, held2 = '0;

  assign ack1 = auto_ack ? resp_ack1 : man_ack;
  assign ack2 = resp_ack2;

  always #5 CLK = ~CLK;

  rank_aer_encoder dut (
    .CLK            (CLK),
    .RST            (RST),
    .sorted_indexes (si),
    .done           (done),
    .AEROUT_ADDR    (addr1),
    .AEROUT_REQ     (req1),
    .AEROUT_ACK     (ack1),
    .busy           (busy1),
    .image_sent     (sent1),
    .overrun        (ovr1)
  );

  rank_aer_encoder #(.NUM_EVENTS(2)) dut2 (
    .CLK            (CLK),
    .RST            (RST),
    .sorted_indexes (si),
    .done           (done2),
    .AEROUT_ADDR    (addr2),
    .AEROUT_REQ     (req2),
    .AEROUT_ACK     (ack2),
    .busy           (busy2),
    .image_sent     (sent2),
    .overrun        (ovr2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Receivers: ACK about 100 ns after REQ rises, release about 100 ns after REQ falls.
  initial forever begin
    wait (auto_ack && req1);
    #103;
    if (req1) resp_ack1 = 1'b1;
    wait (!req1);
    #103;
    resp_ack1 = 1'b0;
  end

  initial forever begin
    wait (req2);
    #103;
    if (req2) resp_ack2 = 1'b1;
    wait (!req2);
    #103;
    resp_ack2 = 1'b0;
  end

  always @(negedge CLK) begin
    if (!RST) begin
      prev_req1 = 1'b0;
    end else begin
      if (req1 && !prev_req1) begin
        check_eq("evt_pending", (q1.size() > 0), 1);
        if (q1.size() > 0) check_eq("addr_evt", addr1, q1.pop_front());
        held1 = addr1;
        ev1++;
      end
      if (!req1 && prev_req1) check_eq("addr_hold", addr1, held1);
      prev_req1 = req1;
      if (sent1) nsent1++;
    end
  end

  always @(negedge CLK) begin
    if (!RST) begin
      prev_req2 = 1'b0;
    end else begin
      if (req2 && !prev_req2) begin
        check_eq("evt_pending2", (q2.size() > 0), 1);
        if (q2.size() > 0) check_eq("addr_evt2", addr2, q2.pop_front());
        held2 = addr2;
        ev2++;
      end
      if (!req2 && prev_req2) check_eq("addr_hold2", addr2, held2);
      prev_req2 = req2;
      if (sent2) nsent2++;
    end
  end

  task automatic start_img(input int a, input int b, input int c, input int d, input int e,
                           input bit on_dut2, input bit expect_it);
    int v[5];
    v = '{a, b, c, d, e};
    for (int i = 0; i < 5; i++) si[i] = v[i][2:0];
    if (expect_it) begin
      for (int i = 0; i < (on_dut2 ? 2 : 5); i++) begin
        if (on_dut2) q2.push_back(v[i]);
        else q1.push_back(v[i]);
      end
    end
    if (on_dut2) done2 = 1'b1;
    else done = 1'b1;
    @(posedge CLK);
    #1;
    done  = 1'b0;
    done2 = 1'b0;
  endtask

  task automatic wait_sent(input bit on_dut2, input int budget);
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!(on_dut2 ? sent2 : sent1) && n < budget);
    check_eq(on_dut2 ? "sent_seen2" : "sent_seen", on_dut2 ? sent2 : sent1, 1);
  endtask

  initial begin
    int base, n, saved_ev, saved_sent;

    repeat (3) @(negedge CLK);
    check_eq("rst_req", req1, 0);
    check_eq("rst_addr", addr1, 0);
    check_eq("rst_busy", busy1, 0);
    check_eq("rst_sent", sent1, 0);
    check_eq("rst_ovr", ovr1, 0);
    check_eq("rst_req2", req2, 0);
    RST = 1'b1;
    repeat (2) @(negedge CLK);

    // Basic image, then a second one started on the image_sent cycle.
    start_img(3, 0, 4, 1, 2, 0, 1);
    check_eq("busy_after_done", busy1, 1);
    wait_sent(0, 1000);
    start_img(2, 4, 1, 3, 0, 0, 1);
    check_eq("chain_busy", busy1, 1);
    check_eq("chain_ovr", ovr1, 0);
    wait_sent(0, 1000);
    repeat (3) @(negedge CLK);
    check_eq("img_sent_cnt", nsent1, 2);
    check_eq("queue_drained", q1.size(), 0);
    check_eq("ovr_clean", ovr1, 0);
    check_eq("idle_busy", busy1, 0);

    // Truncated image on the NUM_EVENTS=2 instance.
    start_img(3, 0, 4, 1, 2, 1, 1);
    wait_sent(1, 1000);
    repeat (60) @(negedge CLK);
    check_eq("trunc_sent_cnt", nsent2, 1);
    check_eq("trunc_events", ev2, 2);
    check_eq("trunc_queue", q2.size(), 0);
    check_eq("trunc_busy", busy2, 0);
    check_eq("trunc_ovr", ovr2, 0);

    // done while busy must be ignored and latch overrun.
    base = ev1;
    start_img(3, 0, 4, 1, 2, 0, 1);
    n = 0;
    while (ev1 < base + 2 && n < 500) begin
      @(negedge CLK);
      n++;
    end
    check_eq("reach_evt2", ev1, base + 2);
    start_img(1, 1, 1, 1, 1, 0, 0);
    @(negedge CLK);
    check_eq("ovr_set", ovr1, 1);
    wait_sent(0, 1000);
    repeat (5) @(negedge CLK);
    check_eq("ovr_queue", q1.size(), 0);
    check_eq("ovr_sent_cnt", nsent1, 3);
    check_eq("ovr_sticky", ovr1, 1);

    // Reset while REQ is high and ACK not yet returned.
    start_img(4, 2, 0, 3, 1, 0, 1);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!req1 && n < 100);
    check_eq("req_before_rst", req1, 1);
    #2 RST = 1'b0;
    #1;
    check_eq("rst_mid_req", req1, 0);
    check_eq("rst_mid_busy", busy1, 0);
    check_eq("rst_mid_addr", addr1, 0);
    check_eq("rst_mid_ovr", ovr1, 0);
    q1.delete();
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    saved_ev   = ev1;
    saved_sent = nsent1;
    repeat (60) @(negedge CLK);
    check_eq("no_resume_ev", ev1, saved_ev);
    check_eq("no_resume_sent", nsent1, saved_sent);
    check_eq("no_resume_busy", busy1, 0);

    // ACK held high before done: REQ waits for ACK to drop.
    auto_ack = 1'b0;
    man_ack  = 1'b1;
    repeat (5) @(negedge CLK);
    start_img(1, 3, 0, 2, 4, 0, 1);
    repeat (8) @(negedge CLK);
    check_eq("req_held_off", req1, 0);
    check_eq("held_busy", busy1, 1);
    #2 man_ack = 1'b0;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!req1 && n < 20);
    check_eq("ack_drop_to_req", n, SYNC_LAT + 1);
    #2 man_ack = 1'b1;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (req1 && n < 20);
    check_eq("ack_rise_to_req_fall", n, SYNC_LAT + 1);
    #2 man_ack = 1'b0;
    auto_ack = 1'b1;
    wait_sent(0, 1000);
    repeat (3) @(negedge CLK);
    check_eq("held_queue", q1.size(), 0);
    check_eq("held_sent_cnt", nsent1, saved_sent + 1);
    check_eq("held_ovr", ovr1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
